// File: rtl/sync_long_if.sv
// Handshake bundle between the long-preamble sync controller and its
// neighbours: sync-short on the input side, FFT/demapper on the output.
interface sync_long_if #(
   parameter int CNT_W = 8,
   parameter int SYM_W = 12
);
   logic             short_found;
   logic             in_strobe;
   logic             corr_strobe;
   logic [CNT_W-1:0] max_idx;
   logic [SYM_W-1:0] n_symbols;
   logic             abort;

   logic             phase_sample;
   logic             quant_en;
   logic             phase_calc_en;
   logic             out_strobe;
   logic             providing_long;
   logic             providing_stream;
   logic [CNT_W-1:0] samp_idx;
   logic [SYM_W-1:0] sym_idx;
   logic             frame_done;
   logic             sync_err;
   logic             busy;

   modport master (
      output short_found, in_strobe, corr_strobe,
      output max_idx, n_symbols, abort,
      input  phase_sample, quant_en, phase_calc_en,
      input  out_strobe, providing_long, providing_stream,
      input  samp_idx, sym_idx, frame_done, sync_err, busy
   );

   modport slave (
      input  short_found, in_strobe, corr_strobe,
      input  max_idx, n_symbols, abort,
      output phase_sample, quant_en, phase_calc_en,
      output out_strobe, providing_long, providing_stream,
      output samp_idx, sym_idx, frame_done, sync_err, busy
   );
endinterface

// File: rtl/sync_long_ctrl.sv
// Long-preamble sync sequencer: phase sample, rest, correlation sweep,
// LONG2 alignment, then alternating CP-strip / data-symbol windows.
module sync_long_ctrl #(
   parameter int N_FFT      = 64,
   parameter int CP_LEN     = 16,
   parameter int REST_COUNT = 112,
   parameter int CORR_SWEEP = 66,
   parameter int LONG2_POS  = 96,
   parameter int TARGET_WIN = 65,
   parameter int CNT_W      = 8,
   parameter int SYM_W      = 12
) (
   input  logic        CLK,
   input  logic        s_RST,
   sync_long_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_SAMPLE, S_REST, S_CORR,
      S_WAIT, S_LONG, S_CP, S_DATA
   } state_t;

   localparam logic [CNT_W-1:0] REST_LAST = CNT_W'(REST_COUNT - 1);
   localparam logic [CNT_W-1:0] CORR_LAST = CNT_W'(CORR_SWEEP - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LONG2_POS - 1);
   localparam logic [CNT_W-1:0] FFT_LAST  = CNT_W'(N_FFT - 1);
   localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'(CP_LEN - 1);
   localparam logic signed [CNT_W+1:0] START_BASE =
      (CNT_W+2)'(2 * TARGET_WIN + 1);
   localparam logic signed [CNT_W+1:0] LONG2_S = (CNT_W+2)'(LONG2_POS);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [SYM_W-1:0] sym;
   logic [SYM_W-1:0] nsym;

   logic                    stb;
   logic                    last;
   logic                    bad;
   logic                    done;
   logic signed [CNT_W+1:0] start;

   // Pick the strobe that advances the current state and flag its final sample
   always_comb begin
      stb  = 1'b0;
      last = 1'b0;
      unique case (state)
         S_SAMPLE: begin
            stb  = bus.in_strobe;
            last = stb;
         end
         S_REST: begin
            stb  = bus.in_strobe;
            last = stb && (cnt == REST_LAST);
         end
         S_CORR: begin
            stb  = bus.in_strobe;
            last = stb && (cnt == CORR_LAST);
         end
         S_WAIT: begin
            stb  = bus.corr_strobe;
            last = stb && (cnt == WAIT_LAST);
         end
         S_LONG, S_DATA: begin
            stb  = bus.corr_strobe;
            last = stb && (cnt == FFT_LAST);
         end
         S_CP: begin
            stb  = bus.corr_strobe;
            last = stb && (cnt == CP_LAST);
         end
         default: begin
            stb  = 1'b0;
            last = 1'b0;
         end
      endcase
   end

   // Signed start position: a peak far from target puts LONG2 out of reach
   assign start = START_BASE - $signed({2'b00, bus.max_idx});
   assign bad   = start[CNT_W+1] || (start >= LONG2_S);
   assign done  = (state == S_DATA) && last && (nsym != '0) &&
                  (sym == nsym - SYM_W'(1));

   // Sequencer: one counter shared by all states, cleared on each transition
   always_ff @(posedge CLK) begin
      if (s_RST || bus.abort) begin
         state <= S_IDLE;
         cnt   <= '0;
         sym   <= '0;
         nsym  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.short_found) begin
                  nsym  <= bus.n_symbols;
                  sym   <= '0;
                  cnt   <= '0;
                  state <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               if (last) state <= S_REST;
            end
            S_REST: begin
               if (last) begin
                  cnt   <= '0;
                  state <= S_CORR;
               end else if (stb) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_CORR: begin
               if (last) begin
                  if (bad) begin
                     cnt   <= '0;
                     state <= S_IDLE;
                  end else begin
                     cnt   <= start[CNT_W-1:0];
                     state <= S_WAIT;
                  end
               end else if (stb) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (last) begin
                  cnt   <= '0;
                  state <= S_LONG;
               end else if (stb) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_LONG: begin
               if (last) begin
                  cnt   <= '0;
                  state <= S_CP;
               end else if (stb) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_CP: begin
               if (last) begin
                  cnt   <= '0;
                  state <= S_DATA;
               end else if (stb) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (last) begin
                  cnt <= '0;
                  if (done) begin
                     sym   <= '0;
                     state <= S_IDLE;
                  end else begin
                     sym   <= sym + SYM_W'(1);
                     state <= S_CP;
                  end
               end else if (stb) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Mealy outputs; abort suppresses every pulse in its own cycle
   assign bus.busy             = (state != S_IDLE);
   assign bus.phase_sample     = (state == S_SAMPLE) && bus.in_strobe &&
                                 !bus.abort;
   assign bus.quant_en         = (state == S_CORR);
   assign bus.phase_calc_en    = (state == S_CORR) || (state == S_WAIT) ||
                                 (state == S_LONG) || (state == S_CP) ||
                                 (state == S_DATA);
   assign bus.providing_long   = (state == S_LONG);
   assign bus.providing_stream = (state == S_DATA);
   assign bus.out_strobe       = (bus.providing_long ||
                                  bus.providing_stream) &&
                                 bus.corr_strobe && !bus.abort;
   assign bus.samp_idx         = (bus.providing_long ||
                                  bus.providing_stream) ? cnt : '0;
   assign bus.sym_idx          = bus.providing_stream ? sym : '0;
   assign bus.frame_done       = done && !bus.abort;
   assign bus.sync_err         = (state == S_CORR) && last && bad &&
                                 !bus.abort;

endmodule

// File: tb/tb_sync_long_ctrl.sv
// Bench for sync_long_ctrl: per-cycle frame-position reference model,
// peak-index vector table and directed abort/reset/restart sequences.
module tb_sync_long_ctrl;

   localparam int CNT_W = 8;
   localparam int SYM_W = 12;
   localparam int PRE   = 1 + 112 + 66;
   localparam int BASE  = 2 * 65 + 1;
   localparam int L2    = 96;

   logic CLK = 1'b0;
   logic s_RST;

   always #5 CLK = ~CLK;

   sync_long_if #(.CNT_W(CNT_W), .SYM_W(SYM_W)) bus ();

   sync_long_ctrl #(
      .CNT_W(CNT_W),
      .SYM_W(SYM_W)
   ) dut (
      .CLK  (CLK),
      .s_RST(s_RST),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   bit m_act;
   int m_k;
   int m_nsym;
   int m_start;

   int mode;
   int cyc_n;

   int st_err, st_done, st_os, st_long, st_data, st_cp;
   int st_wait, st_rest, st_symmax;
   bit seen_long;

   typedef struct {
      logic [7:0] mi;
      int         md;
      bit         err;
      int         wait_n;
   } vec_t;

   vec_t tbl[8];

   function automatic bit bad_peak(input logic [7:0] mi);
      int s;
      s = BASE - int'(mi);
      return (s < 0) || (s >= L2);
   endfunction

   // Expected outputs from the frame position (strobes consumed so far)
   function automatic logic [28:0] model_out();
      logic ps, qe, pc, os, pl, pst, fd, se;
      int sidx, yidx, w, r, blk, off;
      ps = 0; qe = 0; pc = 0; os = 0; pl = 0; pst = 0; fd = 0; se = 0;
      sidx = 0; yidx = 0;
      if (m_act) begin
         if (m_k == 0) begin
            ps = bus.in_strobe;
         end else if (m_k <= 112) begin
            ps = 0;
         end else if (m_k < PRE) begin
            qe = 1;
            pc = 1;
            se = (m_k == PRE - 1) && bus.in_strobe && bad_peak(bus.max_idx);
         end else begin
            pc = 1;
            w  = L2 - m_start;
            r  = m_k - PRE - w;
            if (r >= 0 && r < 64) begin
               pl   = 1;
               os   = bus.corr_strobe;
               sidx = r;
            end else if (r >= 64) begin
               r   = r - 64;
               blk = r / 80;
               off = r % 80;
               if (off >= 16) begin
                  pst  = 1;
                  os   = bus.corr_strobe;
                  sidx = off - 16;
                  yidx = blk % 4096;
                  fd   = bus.corr_strobe && (off == 79) && (m_nsym != 0) &&
                         (blk == m_nsym - 1);
               end
            end
         end
         if (bus.abort) begin
            ps = 0; os = 0; fd = 0; se = 0;
         end
      end
      return {ps, qe, pc, os, pl, pst, sidx[7:0], yidx[11:0], fd, se, m_act};
   endfunction

   function automatic logic [28:0] dut_out();
      return {bus.phase_sample, bus.quant_en, bus.phase_calc_en,
              bus.out_strobe, bus.providing_long, bus.providing_stream,
              bus.samp_idx, bus.sym_idx, bus.frame_done, bus.sync_err,
              bus.busy};
   endfunction

   task automatic chk(input string nm, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic model_update();
      logic [28:0] e;
      bit stb;
      e = model_out();
      if (s_RST || bus.abort) begin
         m_act = 0;
      end else if (!m_act) begin
         if (bus.short_found) begin
            m_act  = 1;
            m_k    = 0;
            m_nsym = int'(bus.n_symbols);
         end
      end else begin
         stb = (m_k < PRE) ? bus.in_strobe : bus.corr_strobe;
         if (stb) begin
            if (m_k == PRE - 1) begin
               if (bad_peak(bus.max_idx)) begin
                  m_act = 0;
               end else begin
                  m_start = BASE - int'(bus.max_idx);
                  m_k++;
               end
            end else if (e[2]) begin
               m_act = 0;
            end else begin
               m_k++;
            end
         end
      end
   endtask

   task automatic check_cycle();
      logic [28:0] e, a;
      e = model_out();
      a = dut_out();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL cycle t=%0t k=%0d: got %h want %h", $time, m_k, a, e);
      end
      if (bus.sync_err) st_err++;
      if (bus.frame_done) st_done++;
      if (bus.out_strobe) st_os++;
      if (bus.out_strobe && bus.providing_long) st_long++;
      if (bus.out_strobe && bus.providing_stream) st_data++;
      if (bus.providing_long) seen_long = 1;
      if (bus.busy && bus.phase_calc_en && !bus.quant_en &&
          !bus.providing_long && !bus.providing_stream && bus.corr_strobe) begin
         if (seen_long) st_cp++;
         else st_wait++;
      end
      if (bus.busy && bus.in_strobe && !bus.phase_sample && !bus.quant_en &&
          !bus.phase_calc_en) st_rest++;
      if (bus.providing_stream && int'(bus.sym_idx) > st_symmax)
         st_symmax = int'(bus.sym_idx);
      model_update();
   endtask

   task automatic tick();
      @(negedge CLK);
      check_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_strobes();
      case (mode)
         0: begin
            bus.in_strobe   = 1'b1;
            bus.corr_strobe = 1'b1;
         end
         1: begin
            bus.in_strobe   = (cyc_n % 3 == 0);
            bus.corr_strobe = (cyc_n % 3 == 0);
         end
         default: begin
            bus.in_strobe   = ($urandom_range(0, 4) != 0);
            bus.corr_strobe = ($urandom_range(0, 3) != 0);
         end
      endcase
      cyc_n++;
   endtask

   task automatic start_frame(input logic [7:0] mi, input int ns, input int md);
      st_err = 0; st_done = 0; st_os = 0; st_long = 0; st_data = 0;
      st_cp = 0; st_wait = 0; st_rest = 0; st_symmax = 0; seen_long = 0;
      mode            = md;
      bus.max_idx     = mi;
      bus.n_symbols   = SYM_W'(ns);
      bus.short_found = 1'b1;
      set_strobes();
      tick();
      bus.short_found = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] mi, input int ns, input int md,
                            input int sf_at);
      start_frame(mi, ns, md);
      for (int n = 0; n < 6000; n++) begin
         bus.short_found = (n == sf_at);
         set_strobes();
         tick();
         if (!bus.busy) break;
      end
      bus.short_found = 1'b0;
      chk("frame_end_busy", bus.busy, 0);
   endtask

   initial begin
      bit found;
      m_act = 0; m_k = 0; m_nsym = 0; m_start = 0;
      mode = 0; cyc_n = 0;
      bus.short_found = 0; bus.in_strobe = 0; bus.corr_strobe = 0;
      bus.max_idx = '0; bus.n_symbols = '0; bus.abort = 0;

      tbl[0] = '{8'd65,  2, 1'b0, 30};
      tbl[1] = '{8'd30,  2, 1'b1, 0};
      tbl[2] = '{8'd35,  0, 1'b1, 0};
      tbl[3] = '{8'd36,  2, 1'b0, 1};
      tbl[4] = '{8'd131, 2, 1'b0, 96};
      tbl[5] = '{8'd132, 0, 1'b1, 0};
      tbl[6] = '{8'd0,   2, 1'b1, 0};
      tbl[7] = '{8'd255, 1, 1'b1, 0};

      s_RST = 1'b1;
      tick();
      tick();
      s_RST = 1'b0;
      chk("reset_outputs", dut_out(), 0);
      tick();

      // Continuous strobes, two symbols
      run_frame(8'd65, 2, 0, -1);
      chk("cont_wait", st_wait, 30);
      chk("cont_long", st_long, 64);
      chk("cont_cp", st_cp, 32);
      chk("cont_data", st_data, 128);
      chk("cont_done", st_done, 1);
      chk("cont_symmax", st_symmax, 1);
      chk("cont_rest", st_rest, 112);

      // 1-in-3 strobes: same per-state counts
      cyc_n = 0;
      run_frame(8'd65, 2, 1, -1);
      chk("gap_wait", st_wait, 30);
      chk("gap_long", st_long, 64);
      chk("gap_cp", st_cp, 32);
      chk("gap_data", st_data, 128);
      chk("gap_done", st_done, 1);

      // Peak-index table: start boundaries and error path
      foreach (tbl[i]) begin
         run_frame(tbl[i].mi, 1, tbl[i].md, -1);
         chk($sformatf("tbl%0d_err", i), st_err, tbl[i].err);
         chk($sformatf("tbl%0d_wait", i), st_wait, tbl[i].wait_n);
         chk($sformatf("tbl%0d_os", i), st_os, tbl[i].err ? 0 : 128);
         chk($sformatf("tbl%0d_done", i), st_done, tbl[i].err ? 0 : 1);
      end

      // short_found during REST is ignored
      run_frame(8'd65, 1, 0, 40);
      chk("sf_rest_len", st_rest, 112);
      chk("sf_rest_done", st_done, 1);

      // Abort at DATA sample 20 of symbol 0, then clean restart
      start_frame(8'd65, 3, 0);
      found = 0;
      for (int n = 0; n < 2000 && !found; n++) begin
         set_strobes();
         tick();
         found = bus.providing_stream && bus.samp_idx == 8'd20 &&
                 bus.sym_idx == '0;
      end
      chk("abort_reach", found, 1);
      bus.abort = 1'b1;
      set_strobes();
      tick();
      bus.abort = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", st_done, 0);
      tick();
      run_frame(8'd65, 2, 0, -1);
      chk("restart_data", st_data, 128);
      chk("restart_done", st_done, 1);

      // Unlimited symbols, then reset mid-DATA
      start_frame(8'd65, 0, 2);
      found = 0;
      for (int n = 0; n < 4000 && !found; n++) begin
         set_strobes();
         tick();
         found = bus.providing_stream && bus.sym_idx == 12'd6 &&
                 bus.samp_idx == 8'd10;
      end
      chk("unl_reach", found, 1);
      chk("unl_done", st_done, 0);
      chk("unl_symmax", st_symmax, 6);
      s_RST = 1'b1;
      set_strobes();
      tick();
      chk("rst_mid_data", dut_out(), 0);
      s_RST = 1'b0;
      tick();

      // Randomized frames against the model
      for (int i = 0; i < 6; i++) begin
         run_frame(8'($urandom_range(20, 140)), $urandom_range(1, 3), 2, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
